// File: rtl/wallace_dot_acc.sv
// wallace_dot_acc
//   Downstream consumer of the pipelined 8x8 Wallace multiplier. Each operand
//   pair launched into the multiplier is tagged; the tag travels down a
//   MUL_LAT-deep delay line so that it lines up with the matching product.
//   A programmed number of tagged products is summed with saturation, and the
//   result is offered on a valid/ready handshake.
//
// Ports
//   clk         system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   start       begin a new dot product (sampled in IDLE only)
//   len         number of products to accumulate, sampled with start
//   issue_valid operand pair launched into the multiplier this cycle
//   prod        multiplier product (unsigned)
//   busy        high while accumulating or holding a result
//   sum         accumulated result, stable while sum_valid
//   sum_valid   result available
//   sum_ready   consumer accepts result
//   ovf         result was saturated; valid with sum_valid
//   drop        one-cycle pulse: tagged product arrived outside ACC, discarded
module wallace_dot_acc #(
  parameter int PW      = 17,
  parameter int MUL_LAT = 4,
  parameter int ACC_W   = 24,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             issue_valid,
  input  logic [PW-1:0]    prod,
  output logic             busy,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             ovf,
  output logic             drop
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [MUL_LAT-1:0] r_tag;
  logic [MUL_LAT:0]   w_tag_shift;
  logic               w_tag;

  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_sum;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_ovf;

  logic [ACC_W:0]     w_nxt;
  logic               w_sat;
  logic [ACC_W-1:0]   w_clamped;
  logic               w_last;

  // Concatenation form keeps the shift legal even for MUL_LAT == 1.
  assign w_tag_shift = {r_tag, issue_valid};
  assign w_tag       = r_tag[MUL_LAT-1];

  // One extra bit catches the carry out of the accumulator for saturation.
  assign w_nxt     = {1'b0, r_acc} + {{(ACC_W + 1 - PW){1'b0}}, prod};
  assign w_sat     = w_nxt[ACC_W];
  assign w_clamped = w_sat ? '1 : w_nxt[ACC_W-1:0];
  assign w_last    = (r_cnt == LEN_W'(1));

  assign sum = r_sum;
  assign ovf = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    sum_valid   = 1'b0;
    drop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        drop = w_tag;
        if (start) begin
          w_state_nxt = (len != '0) ? S_ACC : S_HOLD;
        end
      end
      S_ACC: begin
        busy = 1'b1;
        if (w_tag && w_last) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        busy      = 1'b1;
        sum_valid = 1'b1;
        drop      = w_tag;
        if (sum_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
      r_acc <= '0;
      r_sum <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_tag <= w_tag_shift[MUL_LAT-1:0];
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ovf <= 1'b0;
            if (len != '0) begin
              r_acc <= '0;
              r_cnt <= len;
            end else begin
              r_sum <= '0;
            end
          end
        end
        S_ACC: begin
          if (w_tag) begin
            r_cnt <= r_cnt - LEN_W'(1);
            if (w_sat) begin
              r_ovf <= 1'b1;
            end
            if (w_last) begin
              r_sum <= w_clamped;
            end else begin
              r_acc <= w_clamped;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wallace_dot_acc.sv
module tb_wallace_dot_acc;

  localparam int PW      = 17;
  localparam int MUL_LAT = 4;
  localparam int ACC_W   = 20;
  localparam int LEN_W   = 8;
  localparam longint MAXV = (64'sd1 <<< ACC_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             issue_valid;
  logic [PW-1:0]    prod;
  logic             busy;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready;
  logic             ovf;
  logic             drop;

  wallace_dot_acc #(
    .PW(PW),
    .MUL_LAT(MUL_LAT),
    .ACC_W(ACC_W),
    .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .len(len),
    .issue_valid(issue_valid),
    .prod(prod),
    .busy(busy),
    .sum(sum),
    .sum_valid(sum_valid),
    .sum_ready(sum_ready),
    .ovf(ovf),
    .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the multiplier: fixed-latency product pipe.
  logic [7:0]    op_a, op_b;
  logic [PW-1:0] pipe [MUL_LAT];
  initial for (int i = 0; i < MUL_LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= PW'(op_a) * PW'(op_b);
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign prod = pipe[MUL_LAT-1];

  typedef struct {
    longint s;
    bit     o;
  } exp_t;
  exp_t exp_q[$];

  int vecs = 0;
  int errs = 0;
  int drop_cnt = 0;
  int exp_drops = 0;

  int unsigned la [64];
  int unsigned lb [64];

  function automatic void chk(input string name, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts drop pulses, checks sum stability while valid, and
  // pops/compares the scoreboard on each accepted result.
  bit           prev_v = 0;
  logic [ACC_W-1:0] held_sum;
  always @(negedge clk) begin
    if (drop) drop_cnt++;
    if (sum_valid) begin
      if (prev_v) chk("sum_stable", longint'(sum), longint'(held_sum));
      held_sum = sum;
      prev_v   = 1;
      if (sum_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sum", longint'(sum), e.s);
          chk("ovf", longint'(ovf), longint'(e.o));
        end
      end
    end else begin
      prev_v = 0;
    end
  end

  // Runs one vector of n products from la/lb. gap<0 picks random gaps.
  // hold = extra cycles of sum_ready low after valid; 0 raises ready early.
  // pre = launch a stray pair whose tag lands on the start cycle.
  task automatic run_vec(input int n, input int gap, input int hold, input bit pre);
    longint tot = 0;
    exp_t   e;
    for (int i = 0; i < n; i++) tot += longint'(la[i]) * longint'(lb[i]);
    e.s = (tot > MAXV) ? MAXV : tot;
    e.o = (tot > MAXV);
    if (pre) begin
      issue_valid = 1; op_a = 8'($urandom); op_b = 8'($urandom);
      tick();
      issue_valid = 0;
      repeat (3) tick();
      exp_drops++;
    end
    exp_q.push_back(e);
    start = 1; len = LEN_W'(n);
    tick();
    start = 0; len = LEN_W'($urandom);
    chk("busy_acc", longint'(busy), 1);
    for (int i = 0; i < n; i++) begin
      issue_valid = 1; op_a = 8'(la[i]); op_b = 8'(lb[i]);
      tick();
      issue_valid = 0;
      if (i < n - 1) repeat ((gap < 0) ? $urandom_range(2, 0) : gap) tick();
    end
    if (hold == 0) sum_ready = 1;
    repeat (3) tick();
    chk("lat_early", longint'(sum_valid), 0);
    tick();
    chk("lat_valid", longint'(sum_valid), 1);
    if (hold > 0) begin
      for (int j = 0; j < hold; j++) begin
        tick();
        chk("hold_valid", longint'(sum_valid), 1);
      end
      sum_ready = 1;
    end
    tick();
    sum_ready = 0;
    chk("release_valid", longint'(sum_valid), 0);
    chk("release_idle", longint'(busy), 0);
  endtask

  initial begin
    rst_n = 0; start = 0; len = '0; issue_valid = 0;
    op_a = '0; op_b = '0; sum_ready = 0;
    repeat (2) tick();
    chk("rst_busy", longint'(busy), 0);
    chk("rst_valid", longint'(sum_valid), 0);
    chk("rst_sum", longint'(sum), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_drop", longint'(drop), 0);
    rst_n = 1;
    tick();

    // Single vector of three max products.
    for (int i = 0; i < 3; i++) begin la[i] = 255; lb[i] = 255; end
    run_vec(3, 0, 2, 0);
    chk("t1_no_drop", drop_cnt, 0);

    // Gapped issue, consumer stalls.
    for (int i = 0; i < 4; i++) begin la[i] = i + 1; lb[i] = 1; end
    run_vec(4, 2, 4, 0);

    // Saturation then a clean vector.
    for (int i = 0; i < 17; i++) begin la[i] = 255; lb[i] = 255; end
    run_vec(17, 0, 1, 0);
    la[0] = 5; lb[0] = 1;
    run_vec(1, 1, 0, 0);

    // len = 0: immediate empty result; tag and start during HOLD are ignored.
    begin
      exp_t e;
      e.s = 0; e.o = 0;
      exp_q.push_back(e);
      start = 1; len = '0;
      tick();
      chk("len0_valid", longint'(sum_valid), 1);
      len = LEN_W'(3);
      issue_valid = 1; op_a = 8'd9; op_b = 8'd9;
      tick();
      issue_valid = 0;
      repeat (5) tick();
      exp_drops++;
      chk("len0_drop", drop_cnt, exp_drops);
      chk("len0_still_valid", longint'(sum_valid), 1);
      sum_ready = 1;
      tick();
      sum_ready = 0; start = 0;
      chk("len0_exit", longint'(sum_valid), 0);
      tick();
      chk("len0_idle", longint'(busy), 0);
    end

    // Stray product in IDLE.
    issue_valid = 1; op_a = 8'd3; op_b = 8'd3;
    tick();
    issue_valid = 0;
    repeat (2) tick();
    chk("stray_early", longint'(drop), 0);
    tick();
    chk("stray_drop", longint'(drop), 1);
    chk("stray_idle", longint'(busy), 0);
    exp_drops++;
    tick();
    chk("stray_pulse_end", longint'(drop), 0);
    chk("stray_idle2", longint'(busy), 0);

    // Reset in the middle of a vector.
    start = 1; len = LEN_W'(5);
    tick();
    start = 0;
    issue_valid = 1; op_a = 8'd100; op_b = 8'd100;
    repeat (2) tick();
    issue_valid = 0;
    repeat (5) tick();
    rst_n = 0;
    #1;
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_valid", longint'(sum_valid), 0);
    chk("mid_rst_sum", longint'(sum), 0);
    chk("mid_rst_ovf", longint'(ovf), 0);
    chk("mid_rst_drop", longint'(drop), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();
    chk("post_rst_idle", longint'(busy), 0);
    la[0] = 7; lb[0] = 1; la[1] = 8; lb[1] = 1;
    run_vec(2, 0, 1, 0);

    // Tag landing on the start cycle is dropped, not accumulated.
    for (int i = 0; i < 3; i++) begin la[i] = $urandom_range(255); lb[i] = $urandom_range(255); end
    run_vec(3, 1, 1, 1);

    // Randomized vectors.
    for (int v = 0; v < 12; v++) begin
      int n;
      n = $urandom_range(20, 1);
      for (int i = 0; i < n; i++) begin
        la[i] = $urandom_range(255);
        lb[i] = $urandom_range(255);
      end
      run_vec(n, -1, $urandom_range(3, 0), 1'($urandom_range(1)));
    end

    repeat (10) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("drop_total", drop_cnt, exp_drops);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
